window_gen_3x3: RTL and testbench

- Streaming 3x3 neighbourhood generator that produces the nine-pixel window bus consumed by the transmission-estimation stage and by edge detection.
- Accepts 24-bit RGB pixels in raster order and buffers two full image lines internally.
- Emits exactly one window per image pixel, with border-replicated (clamped) neighbours.
- After the last input pixel of a frame, self-flushes the trailing row and column without further input.

---
 rtl/window_gen_3x3.sv | 140 ++++++++++++++
 tb/tb_window_gen_3x3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// Purpose: streaming 3x3 border-clamped window generator over a raster RGB stream with two line buffers.
// Latency: the window centred on (r,c) is registered one cycle after the step with index (r+1)*W+c+1.
// Backpressure: input_ready drops for W+1 cycles while the trailing row/column self-flushes; otherwise always ready.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] input_pixel,
  input  logic        input_is_valid,
  output logic        input_ready,
  output logic [23:0] output_pixel_1,
  output logic [23:0] output_pixel_2,
  output logic [23:0] output_pixel_3,
  output logic [23:0] output_pixel_4,
  output logic [23:0] output_pixel_5,
  output logic [23:0] output_pixel_6,
  output logic [23:0] output_pixel_7,
  output logic [23:0] output_pixel_8,
  output logic [23:0] output_pixel_9,
  output logic        output_is_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 2);
  localparam int FW = $clog2(IMG_WIDTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [FW-1:0] flush_cnt;

  // Line buffers: lb_top holds the line two above the incoming one, lb_mid the line directly above.
  logic [23:0] lb_top [IMG_WIDTH];
  logic [23:0] lb_mid [IMG_WIDTH];

  // Two most recent columns (top/mid/bottom), already row-clamped when captured.
  logic [23:0] a_top, a_mid, a_bot;
  logic [23:0] b_top, b_mid, b_bot;

  logic        step;
  logic [23:0] rd_top, rd_mid;
  logic [23:0] new_top, new_mid, new_bot;
  logic        col_last, col_wrap, left_edge, emit, flush_end;

  assign input_ready = (state == RUN);
  assign step        = (state == FLUSH) || input_is_valid;
  assign rd_top      = lb_top[col_cnt];
  assign rd_mid      = lb_mid[col_cnt];

  // Row clamping: a column whose centre row is 0 replicates row 0 upward; flush columns replicate the last row downward.
  assign new_top   = (row_cnt == RW'(1)) ? rd_mid : rd_top;
  assign new_mid   = rd_mid;
  assign new_bot   = (state == FLUSH) ? rd_mid : input_pixel;

  assign col_last  = (col_cnt == CW'(IMG_WIDTH - 1));
  assign col_wrap  = (col_cnt == '0);
  assign left_edge = (col_cnt == CW'(1));
  assign flush_end = (state == FLUSH) && (flush_cnt == FW'(IMG_WIDTH));

  // No window exists until the incoming position has reached (1,1).
  assign emit = step && (row_cnt != '0) && !((row_cnt == RW'(1)) && col_wrap);

  // Line buffer update: read and write share the current column address.
  always_ff @(posedge clk) begin
    if (step) begin
      lb_top[col_cnt] <= rd_mid;
      lb_mid[col_cnt] <= new_bot;
    end
  end

  // Step counters and RUN/FLUSH sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      col_cnt   <= '0;
      row_cnt   <= '0;
      flush_cnt <= '0;
    end else if (step) begin
      if (flush_end) begin
        state     <= RUN;
        col_cnt   <= '0;
        row_cnt   <= '0;
        flush_cnt <= '0;
      end else begin
        col_cnt <= col_last ? '0 : col_cnt + CW'(1);
        if (col_last) begin
          row_cnt <= row_cnt + RW'(1);
        end
        if (state == FLUSH) begin
          flush_cnt <= flush_cnt + FW'(1);
        end
        if ((state == RUN) && col_last && (row_cnt == RW'(IMG_HEIGHT - 1))) begin
          state <= FLUSH;
        end
      end
    end
  end

  // Column history shift: one new column per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_top <= '0; a_mid <= '0; a_bot <= '0;
      b_top <= '0; b_mid <= '0; b_bot <= '0;
    end else if (step) begin
      a_top <= b_top;   a_mid <= b_mid;   a_bot <= b_bot;
      b_top <= new_top; b_mid <= new_mid; b_bot <= new_bot;
    end
  end

  // Registered window: left column replicates the centre at column 0, right column replicates it at column W-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_is_valid <= 1'b0;
      frame_done      <= 1'b0;
      output_pixel_1  <= '0; output_pixel_2 <= '0; output_pixel_3 <= '0;
      output_pixel_4  <= '0; output_pixel_5 <= '0; output_pixel_6 <= '0;
      output_pixel_7  <= '0; output_pixel_8 <= '0; output_pixel_9 <= '0;
    end else begin
      output_is_valid <= emit;
      frame_done      <= emit && flush_end;
      if (emit) begin
        output_pixel_1 <= left_edge ? b_top : a_top;
        output_pixel_4 <= left_edge ? b_mid : a_mid;
        output_pixel_7 <= left_edge ? b_bot : a_bot;
        output_pixel_2 <= b_top;
        output_pixel_5 <= b_mid;
        output_pixel_8 <= b_bot;
        output_pixel_3 <= col_wrap ? b_top : new_top;
        output_pixel_6 <= col_wrap ? b_mid : new_mid;
        output_pixel_9 <= col_wrap ? b_bot : new_bot;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Purpose: self-checking bench for window_gen_3x3 at W=4, H=3 with a sequence-index reference model.
// Latency: compares every cycle on the falling edge against the step taken at the previous rising edge.
// Backpressure: drives valid during flush and with bubbles; the model expects input_ready low during flush.
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int WH = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] input_pixel;
  logic        input_is_valid;
  logic        input_ready;
  logic [23:0] output_pixel_1, output_pixel_2, output_pixel_3;
  logic [23:0] output_pixel_4, output_pixel_5, output_pixel_6;
  logic [23:0] output_pixel_7, output_pixel_8, output_pixel_9;
  logic        output_is_valid;
  logic        frame_done;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .input_pixel(input_pixel), .input_is_valid(input_is_valid), .input_ready(input_ready),
    .output_pixel_1(output_pixel_1), .output_pixel_2(output_pixel_2), .output_pixel_3(output_pixel_3),
    .output_pixel_4(output_pixel_4), .output_pixel_5(output_pixel_5), .output_pixel_6(output_pixel_6),
    .output_pixel_7(output_pixel_7), .output_pixel_8(output_pixel_8), .output_pixel_9(output_pixel_9),
    .output_is_valid(output_is_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: frame image, sequence index, expected registered outputs.
  logic [23:0]  img [WH];
  int           k = 0;
  bit           known = 1'b0;
  logic         exp_vld = 1'b0;
  logic         exp_fd = 1'b0;
  logic [215:0] exp_win = '0;
  int           mcyc = 0;
  int           acc5_cyc = -100;
  logic [215:0] got [$];
  int           got_cyc [$];

  task automatic chk(input string nm, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Window for centre index ci straight from the clamped-neighbourhood definition.
  function automatic logic [215:0] win(input int ci);
    logic [215:0] w = '0;
    int r = ci / W;
    int c = ci % W;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[191:0], img[clampi(r + dr, H - 1) * W + clampi(c + dc, W - 1)]};
    return w;
  endfunction

  function automatic logic [215:0] lit9(input int b1, b2, b3, b4, b5, b6, b7, b8, b9);
    logic [215:0] w = '0;
    int v [9];
    v = '{b1, b2, b3, b4, b5, b6, b7, b8, b9};
    for (int i = 0; i < 9; i++) w = {w[191:0], {3{8'(v[i])}}};
    return w;
  endfunction

  task automatic monitor();
    logic [215:0] act;
    forever begin
      @(negedge clk);
      mcyc++;
      act = {output_pixel_1, output_pixel_2, output_pixel_3, output_pixel_4, output_pixel_5,
             output_pixel_6, output_pixel_7, output_pixel_8, output_pixel_9};
      if (known) begin
        chk("output_is_valid", 216'(output_is_valid), 216'(exp_vld));
        chk("frame_done", 216'(frame_done), 216'(exp_fd));
        chk("window", act, exp_win);
        chk("input_ready", 216'(input_ready), 216'(k < WH));
      end
      if (output_is_valid === 1'b1) begin
        got.push_back(act);
        got_cyc.push_back(mcyc);
      end
      if (rst) begin
        known   = 1'b1;
        exp_vld = 1'b0;
        exp_fd  = 1'b0;
        exp_win = '0;
        k       = 0;
      end else if (known) begin
        if (k >= WH || input_is_valid) begin
          if (k < WH) img[k] = input_pixel;
          if (k == W + 1) acc5_cyc = mcyc;
          if (k >= W + 1) begin
            exp_vld = 1'b1;
            exp_win = win(k - W - 1);
            exp_fd  = (k == WH + W);
          end else begin
            exp_vld = 1'b0;
            exp_fd  = 1'b0;
          end
          k++;
          if (k > WH + W) k = 0;
        end else begin
          exp_vld = 1'b0;
          exp_fd  = 1'b0;
        end
      end
    end
  endtask

  // Offers n pixels {v,v,v}, v = base+index; bubble drops valid on every other cycle.
  task automatic send(input int base, input int n, input bit bubble);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < n && cyc < 200) begin
      input_is_valid = (bubble && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      input_pixel    = {3{8'(base + idx)}};
      @(negedge clk);
      acc = input_ready && input_is_valid;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    if (idx < n) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d of %0d", idx, n);
    end
  endtask

  // Holds valid high into the flush for three cycles, then waits for input_ready; returns the low-cycle count.
  task automatic drain(output int low);
    bit r;
    low = 0;
    input_is_valid = 1'b1;
    input_pixel    = 24'hAAAAAA;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = input_ready;
      if (r) break;
      low++;
      @(posedge clk);
      #1;
      if (low == 3) input_is_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    input_is_valid = 1'b0;
  endtask

  initial begin
    int b;
    int low;
    rst = 1'b1;
    input_is_valid = 1'b0;
    input_pixel = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Continuous valid through the flush.
    b = got.size();
    send(0, WH, 1'b0);
    drain(low);
    chk("flush_ready_low_cycles", 216'(low), 216'(W + 1));
    chk("frame1_window_count", 216'(got.size() - b), 216'(WH));
    if (got.size() - b == WH) begin
      chk("first_window_latency", 216'(got_cyc[b]), 216'(acc5_cyc + 1));
      chk("centre_0_0", got[b], lit9(0, 0, 1, 0, 0, 1, 4, 4, 5));
      chk("centre_1_2", got[b + 6], lit9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("centre_2_3", got[b + 11], lit9(6, 7, 7, 10, 11, 11, 10, 11, 11));
    end

    // Bubbles on alternate cycles.
    b = got.size();
    send(0, WH, 1'b1);
    drain(low);
    chk("bubble_window_count", 216'(got.size() - b), 216'(WH));
    if (got.size() - b == WH) begin
      chk("bubble_centre_0_0", got[b], lit9(0, 0, 1, 0, 0, 1, 4, 4, 5));
      chk("bubble_centre_1_2", got[b + 6], lit9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    end

    // Reset mid-frame after pixel 7, then a full restart.
    send(0, 8, 1'b0);
    input_is_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready", 216'(input_ready), 216'(1));
    chk("reset_valid", 216'(output_is_valid), 216'(0));
    chk("reset_pixel5", 216'(output_pixel_5), 216'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    input_is_valid = 1'b0;
    b = got.size();
    send(0, WH, 1'b0);
    drain(low);
    chk("restart_window_count", 216'(got.size() - b), 216'(WH));
    if (got.size() - b == WH) begin
      chk("restart_centre_0_0", got[b], lit9(0, 0, 1, 0, 0, 1, 4, 4, 5));
      chk("restart_centre_2_3", got[b + 11], lit9(6, 7, 7, 10, 11, 11, 10, 11, 11));
    end

    // Back-to-back frames, second offset by 100.
    b = got.size();
    send(0, WH, 1'b0);
    send(100, WH, 1'b0);
    drain(low);
    chk("b2b_window_count", 216'(got.size() - b), 216'(2 * WH));
    if (got.size() - b == 2 * WH) begin
      chk("frame2_centre_0_0", got[b + WH], lit9(100, 100, 101, 100, 100, 101, 104, 104, 105));
      chk("frame2_centre_2_3", got[b + 2 * WH - 1], lit9(106, 107, 107, 110, 111, 111, 110, 111, 111));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
